// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath it steers: instruction
// and memory handshake in, bus-drive/load/ALU/memory controls and status out.
interface control_sequencer_if;
    logic [31:0] IRval;
    logic        mem_ready;
    logic        PCout, Zlowout, MDRout, Rout, BAout, Cout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, Rin;
    logic        Gra, Grb, Grc;
    logic        IncPC, ADD, SUB, AND, OR, SHR, SHL;
    logic        Read, Write;
    logic        run;
    logic        illegal;
    logic [3:0]  state;

    modport master (
        input  IRval, mem_ready,
        output PCout, Zlowout, MDRout, Rout, BAout, Cout,
        output PCin, IRin, MARin, MDRin, Yin, Zin, Rin,
        output Gra, Grb, Grc,
        output IncPC, ADD, SUB, AND, OR, SHR, SHL,
        output Read, Write, run, illegal, state
    );

    modport slave (
        output IRval, mem_ready,
        input  PCout, Zlowout, MDRout, Rout, BAout, Cout,
        input  PCin, IRin, MARin, MDRin, Yin, Zin, Rin,
        input  Gra, Grb, Grc,
        input  IncPC, ADD, SUB, AND, OR, SHR, SHL,
        input  Read, Write, run, illegal, state
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, per-opcode execute T3-T7, HALT.
// All control outputs are registered alongside the state they belong to.
module control_sequencer (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3, S_T4 = 4'd4,
        S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7, S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_ADDI, C_LD, C_ST, C_NOP, C_HALT, C_ILL
    } op_class_t;

    typedef struct packed {
        logic PCout, Zlowout, MDRout, Rout, BAout, Cout;
        logic PCin, IRin, MARin, MDRin, Yin, Zin, Rin;
        logic Gra, Grb, Grc;
        logic IncPC, ADD, SUB, AND, OR, SHR, SHL;
        logic Read, Write;
    } ctl_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t k;
        case (op)
            OP_LD:   k = C_LD;
            OP_ST:   k = C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: k = C_ALU;
            OP_ADDI: k = C_ADDI;
            OP_NOP:  k = C_NOP;
            OP_HALT: k = C_HALT;
            default: k = C_ILL;
        endcase
        return k;
    endfunction

    // Control word shown while sitting in state s; first_t1 marks the entry cycle of T1.
    function automatic ctl_t decode(input state_t s, input logic [4:0] op, input logic first_t1);
        ctl_t      c;
        op_class_t k;
        c = '0;
        k = classify(op);
        case (s)
            S_T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; end
            S_T1: begin c.Zlowout = 1'b1; c.PCin = first_t1; c.Read = 1'b1; c.MDRin = 1'b1; end
            S_T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
            S_T3: begin
                if (k == C_ALU || k == C_ADDI) begin
                    c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1;
                end else if (k == C_LD || k == C_ST) begin
                    c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1;
                end
            end
            S_T4: begin
                c.Zin = 1'b1;
                if (k == C_ALU) begin
                    c.Grc = 1'b1; c.Rout = 1'b1;
                    case (op)
                        OP_ADD:  c.ADD = 1'b1;
                        OP_SUB:  c.SUB = 1'b1;
                        OP_AND:  c.AND = 1'b1;
                        OP_OR:   c.OR  = 1'b1;
                        OP_SHR:  c.SHR = 1'b1;
                        OP_SHL:  c.SHL = 1'b1;
                        default: ;
                    endcase
                end else begin
                    c.Cout = 1'b1; c.ADD = 1'b1;
                end
            end
            S_T5: begin
                c.Zlowout = 1'b1;
                if (k == C_LD || k == C_ST) c.MARin = 1'b1;
                else begin c.Gra = 1'b1; c.Rin = 1'b1; end
            end
            S_T6: begin
                c.MDRin = 1'b1;
                if (k == C_ST) begin c.Gra = 1'b1; c.Rout = 1'b1; end
                else c.Read = 1'b1;
            end
            S_T7: begin
                if (k == C_ST) c.Write = 1'b1;
                else begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t    state_q, state_n;
    ctl_t      ctl_q;
    logic      run_q, illegal_q, first_n;
    logic [4:0] op_q, op_n;
    op_class_t cls_n;

    // Opcode is captured as IR loads; execute states never look at live IRval.
    always_comb begin
        op_n    = (state_q == S_T2) ? bus.IRval[31:27] : op_q;
        cls_n   = classify(op_n);
        state_n = state_q;
        first_n = 1'b0;
        case (state_q)
            S_T0: if (run_q) begin state_n = S_T1; first_n = 1'b1; end
            S_T1: if (bus.mem_ready) state_n = S_T2;
            S_T2: state_n = S_T3;
            S_T3: begin
                case (cls_n)
                    C_NOP:          state_n = S_T0;
                    C_HALT, C_ILL:  state_n = S_HALT;
                    default:        state_n = S_T4;
                endcase
            end
            S_T4: state_n = S_T5;
            S_T5: state_n = (cls_n == C_LD || cls_n == C_ST) ? S_T6 : S_T0;
            S_T6: if (cls_n == C_ST || bus.mem_ready) state_n = S_T7;
            S_T7: if (cls_n == C_LD || bus.mem_ready) state_n = S_T0;
            S_HALT: state_n = S_HALT;
            default: state_n = S_T0;
        endcase
    end

    // run_q low in T0 marks the idle cycle just after reset, which re-enters T0 with run high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_T0;
            ctl_q     <= '0;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
            op_q      <= '0;
        end else begin
            state_q <= state_n;
            ctl_q   <= decode(state_n, op_n, first_n);
            run_q   <= (state_n != S_HALT);
            if (state_q == S_T2) op_q <= bus.IRval[31:27];
            if (state_q == S_T3 && cls_n == C_ILL) illegal_q <= 1'b1;
        end
    end

    logic unused_ir_fields;
    assign unused_ir_fields = ^bus.IRval[26:0];

    assign bus.PCout = ctl_q.PCout;   assign bus.Zlowout = ctl_q.Zlowout;
    assign bus.MDRout = ctl_q.MDRout; assign bus.Rout = ctl_q.Rout;
    assign bus.BAout = ctl_q.BAout;   assign bus.Cout = ctl_q.Cout;
    assign bus.PCin = ctl_q.PCin;     assign bus.IRin = ctl_q.IRin;
    assign bus.MARin = ctl_q.MARin;   assign bus.MDRin = ctl_q.MDRin;
    assign bus.Yin = ctl_q.Yin;       assign bus.Zin = ctl_q.Zin;
    assign bus.Rin = ctl_q.Rin;       assign bus.Gra = ctl_q.Gra;
    assign bus.Grb = ctl_q.Grb;       assign bus.Grc = ctl_q.Grc;
    assign bus.IncPC = ctl_q.IncPC;   assign bus.ADD = ctl_q.ADD;
    assign bus.SUB = ctl_q.SUB;       assign bus.AND = ctl_q.AND;
    assign bus.OR = ctl_q.OR;         assign bus.SHR = ctl_q.SHR;
    assign bus.SHL = ctl_q.SHL;       assign bus.Read = ctl_q.Read;
    assign bus.Write = ctl_q.Write;
    assign bus.run = run_q;
    assign bus.illegal = illegal_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level reference model emits per-cycle
// stimulus and expected control vectors; a monitor compares every cycle.
module tb_control_sequencer;
  localparam int W = 32;

  // control bit positions in the expected vector [24:0]
  localparam logic [24:0] M_PCOUT = 25'd1 << 0,  M_ZLOWOUT = 25'd1 << 1,  M_MDROUT = 25'd1 << 2;
  localparam logic [24:0] M_ROUT  = 25'd1 << 3,  M_BAOUT   = 25'd1 << 4,  M_COUT   = 25'd1 << 5;
  localparam logic [24:0] M_PCIN  = 25'd1 << 6,  M_IRIN    = 25'd1 << 7,  M_MARIN  = 25'd1 << 8;
  localparam logic [24:0] M_MDRIN = 25'd1 << 9,  M_YIN     = 25'd1 << 10, M_ZIN    = 25'd1 << 11;
  localparam logic [24:0] M_RIN   = 25'd1 << 12, M_GRA     = 25'd1 << 13, M_GRB    = 25'd1 << 14;
  localparam logic [24:0] M_GRC   = 25'd1 << 15, M_INCPC   = 25'd1 << 16, M_ADD    = 25'd1 << 17;
  localparam logic [24:0] M_SUB   = 25'd1 << 18, M_AND     = 25'd1 << 19, M_OR     = 25'd1 << 20;
  localparam logic [24:0] M_SHR   = 25'd1 << 21, M_SHL     = 25'd1 << 22, M_READ   = 25'd1 << 23;
  localparam logic [24:0] M_WRITE = 25'd1 << 24;
  localparam logic [W-1:0] RSTV = 32'h8000_0000;

  // clock/reset block
  logic clk = 1'b1;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_sequencer_if bus();
  control_sequencer dut (.clk(clk), .reset(reset), .bus(bus.master));

  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  logic [33:0]  stim_q[$];
  logic         m_ill = 1'b0;
  int           cur_test = 0;
  logic         built = 1'b0;
  int           checks = 0;
  int           errors = 0;
  logic [4:0]   legal_ops [11] = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                   5'b01000, 5'b01001, 5'b01100, 5'b11010, 5'b11011};

  logic [W-1:0] obs;
  assign obs = {1'b1, bus.illegal, bus.run, bus.state,
                bus.Write, bus.Read, bus.SHL, bus.SHR, bus.OR, bus.AND, bus.SUB, bus.ADD, bus.IncPC,
                bus.Grc, bus.Grb, bus.Gra, bus.Rin, bus.Zin, bus.Yin, bus.MDRin, bus.MARin, bus.IRin,
                bus.PCin, bus.Cout, bus.BAout, bus.Rout, bus.MDRout, bus.Zlowout, bus.PCout};

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [W-1:0] disp(input int st, input logic [24:0] c);
    return {1'b1, m_ill, 1'b1, 4'(st), c};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction

  task automatic step(input logic [W-1:0] d, input logic mr, input logic rst, input logic [31:0] ir);
    exp_q.push_back(d);
    tag_q.push_back(cur_test);
    stim_q.push_back({rst, mr, ir});
  endtask

  // first: what is on the outputs in the cycle reset is first driven
  task automatic reset_seq(input int n, input logic [W-1:0] first, input logic mr);
    step(first, mr, 1'b1, $urandom);
    for (int i = 1; i < n; i++) step(RSTV, rbit(), 1'b1, $urandom);
    m_ill = 1'b0;
    step(RSTV, rbit(), 1'b0, $urandom);
  endtask

  // One instruction from T0; abort_at >= 0 drives reset (with mem_ready=1) in that cycle.
  task automatic run_instr(input logic [31:0] ir, input int w1, input int w2, input int abort_at,
                           input int halt_cycles, input int rst_len);
    logic [W-1:0] d[$];
    logic         m[$];
    logic [4:0]   op;
    logic [24:0]  opm;
    logic [W-1:0] hv;
    int           keep;
    op = ir[31:27];
    opm = '0;
    d.push_back(disp(0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN)); m.push_back(rbit());
    for (int i = 0; i <= w1; i++) begin
      d.push_back(disp(1, (i == 0 ? M_PCIN : 25'd0) | M_ZLOWOUT | M_READ | M_MDRIN));
      m.push_back(i == w1);
    end
    d.push_back(disp(2, M_MDROUT | M_IRIN)); m.push_back(rbit());
    keep = d.size();
    case (op)
      5'b00011: opm = M_ADD;
      5'b00100: opm = M_SUB;
      5'b00101: opm = M_AND;
      5'b00110: opm = M_OR;
      5'b01000: opm = M_SHR;
      5'b01001: opm = M_SHL;
      default:  opm = '0;
    endcase
    if (opm != 0 || op == 5'b01100) begin
      d.push_back(disp(3, M_GRB | M_ROUT | M_YIN)); m.push_back(rbit());
      d.push_back(disp(4, (opm != 0) ? (M_GRC | M_ROUT | opm | M_ZIN) : (M_COUT | M_ADD | M_ZIN)));
      m.push_back(rbit());
      d.push_back(disp(5, M_ZLOWOUT | M_GRA | M_RIN)); m.push_back(rbit());
    end else if (op == 5'b00000 || op == 5'b00010) begin
      d.push_back(disp(3, M_GRB | M_BAOUT | M_YIN)); m.push_back(rbit());
      d.push_back(disp(4, M_COUT | M_ADD | M_ZIN)); m.push_back(rbit());
      d.push_back(disp(5, M_ZLOWOUT | M_MARIN)); m.push_back(rbit());
      if (op == 5'b00000) begin
        for (int i = 0; i <= w2; i++) begin d.push_back(disp(6, M_READ | M_MDRIN)); m.push_back(i == w2); end
        d.push_back(disp(7, M_MDROUT | M_GRA | M_RIN)); m.push_back(rbit());
      end else begin
        d.push_back(disp(6, M_GRA | M_ROUT | M_MDRIN)); m.push_back(rbit());
        for (int i = 0; i <= w2; i++) begin d.push_back(disp(7, M_WRITE)); m.push_back(i == w2); end
      end
    end else begin
      d.push_back(disp(3, 25'd0)); m.push_back(rbit());
    end
    for (int i = 0; i < d.size(); i++) begin
      if (i == abort_at) begin
        reset_seq(rst_len, d[i], 1'b1);
        return;
      end
      step(d[i], m[i], 1'b0, (i < keep) ? ir : $urandom);
    end
    if (op != 5'b11010 && (op == 5'b11011 || !(opm != 0 || op == 5'b01100 || op == 5'b00000 || op == 5'b00010))) begin
      if (op != 5'b11011) m_ill = 1'b1;
      hv = {1'b1, m_ill, 1'b0, 4'd8, 25'd0};
      for (int i = 0; i < halt_cycles; i++) step(hv, rbit(), 1'b0, $urandom);
      reset_seq(rst_len, hv, rbit());
    end
  endtask

  task automatic build();
    logic [4:0] op;
    int         k;
    cur_test = 0;  reset_seq(3, 32'h0, 1'b0);
    cur_test = 1;  run_instr(mk_ir(5'b00011, 4'd1, 4'd2, {4'd3, 15'd0}), 0, 0, -1, 0, 1);
    cur_test = 2;  run_instr(mk_ir(5'b00100, 4'd5, 4'd6, {4'd7, 15'd9}), 3, 0, -1, 0, 1);
    cur_test = 3;  run_instr(mk_ir(5'b00000, 4'd4, 4'd0, 19'h55), 0, 2, -1, 0, 1);
    cur_test = 4;  run_instr(mk_ir(5'b00010, 4'd2, 4'd1, 19'h10), 0, 1, -1, 0, 1);
    cur_test = 5;  run_instr(mk_ir(5'b11010, 4'd0, 4'd0, 19'd0), 1, 0, -1, 0, 1);
    cur_test = 6;
    foreach (legal_ops[i]) run_instr(mk_ir(legal_ops[i], 4'($urandom), 4'($urandom), 19'($urandom)), 0, 0, -1, 2, 1);
    cur_test = 7;  run_instr(mk_ir(5'b11111, 4'd0, 4'd0, 19'd0), 0, 0, -1, 10, 2);
    cur_test = 8;  run_instr(mk_ir(5'b11011, 4'd0, 4'd0, 19'd0), 0, 0, -1, 3, 2);
    cur_test = 9;  run_instr(mk_ir(5'b00000, 4'd1, 4'd1, 19'd1), 2, 0, 2, 0, 2);
    cur_test = 10; run_instr(mk_ir(5'b00000, 4'd3, 4'd2, 19'd7), 0, 2, 6, 0, 1);
    cur_test = 11; run_instr(mk_ir(5'b00010, 4'd3, 4'd2, 19'd7), 0, 2, 7, 0, 1);
    cur_test = 12; run_instr(mk_ir(5'b00011, 4'd1, 4'd2, 19'd3), 0, 0, -1, 0, 1);
    cur_test = 100;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 11);
      if (k < 11) op = legal_ops[k];
      else begin
        op = 5'b11010;
        while (op inside {legal_ops}) op = 5'($urandom_range(0, 31));
      end
      run_instr(mk_ir(op, 4'($urandom), 4'($urandom), 19'($urandom)),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : -1,
                $urandom_range(1, 4), $urandom_range(1, 3));
      cur_test = cur_test + 1;
    end
  endtask

  // driver: one stimulus item per clock cycle
  initial begin
    logic [33:0] s;
    bus.IRval = '0;
    bus.mem_ready = 1'b0;
    build();
    built = 1'b1;
    s = stim_q.pop_front();
    {reset, bus.mem_ready, bus.IRval} = s;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      s = stim_q.pop_front();
      {reset, bus.mem_ready, bus.IRval} = s;
    end
  end

  // monitor / scoreboard: one expected vector per cycle, sampled on the falling edge
  initial begin
    logic [W-1:0] e;
    int           t;
    int           budget;
    int           cyc;
    wait (built);
    budget = exp_q.size() + 50;
    cyc = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e[31]) begin
        checks++;
        if (obs[30:0] !== e[30:0]) begin
          errors++;
          $display("FAIL vector test=%0d cycle=%0d got state=%0d run=%b ill=%b ctl=%h exp state=%0d run=%b ill=%b ctl=%h",
                   t, cyc, obs[28:25], obs[29], obs[30], obs[24:0], e[28:25], e[29], e[30], e[24:0]);
        end
        checks++;
        if ($countones(obs[5:0]) > 1) begin
          errors++;
          $display("FAIL bus_drive test=%0d cycle=%0d got drives=%b required at most one", t, cyc, obs[5:0]);
        end
      end
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout got %0d vectors left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Ports, clock and reset first:
- clk  in  1  single system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- IRval  in  32  instruction register contents from the datapath
- mem_ready  in  1  memory handshake; high when a read or write completes this cycle
- PCout, Zlowout, MDRout, Rout, BAout, Cout  out  1 each  bus-drive selects
- PCin, IRin, MARin, MDRin, Yin, Zin, Rin  out  1 each  register load enables
- Gra, Grb, Grc  out  1 each  register-field selects (ra/rb/rc)
- IncPC, ADD, SUB, AND, OR, SHR, SHL  out  1 each  ALU operation one-hots
- Read, Write  out  1 each  memory strobes
- run  out  1  high while executing; low in HALT
- illegal  out  1  sticky flag for an undefined opcode
- state  out  4  current state code, for debug

Function
REQ-002 Instruction fields: opcode=IRval[31:27], ra=[26:23], rb=[22:19], rc=[18:15], constant C=[18:0].
REQ-003 Opcodes: 00000 ld, 00010 st, 00011 add, 00100 sub, 00101 and, 00110 or, 01000 shr, 01001 shl, 01100 addi, 11010 nop, 11011 halt; every other opcode is illegal.
REQ-004 States: T0..T7 (codes 0..7) and HALT (code 8); there are no other reachable states.
REQ-005 Outputs are Moore, decoded only from state and IRval; any output not listed for a state is 0.
REQ-006 At most one bus-drive select is high in any cycle.
REQ-007 Fetch sequence, every instruction:
- T0: PCout, MARin, IncPC, Zin
- T1: Zlowout, PCin, Read, MDRin
- T2: MDRout, IRin
REQ-008 T1 holds while mem_ready=0, keeping Read and MDRin asserted. PCin is asserted only on the first T1 cycle. T1 advances to T2 on the cycle mem_ready=1.
REQ-009 T2 always advances to T3. T3 onward decode IRval as latched at the end of T2.
REQ-010 Register ALU ops (add, sub, and, or, shr, shl):
- T3: Grb, Rout, Yin
- T4: Grc, Rout, op one-hot, Zin
- T5: Zlowout, Gra, Rin; then T0
REQ-011 addi:
- T3: Grb, Rout, Yin
- T4: Cout, ADD, Zin
- T5: Zlowout, Gra, Rin; then T0
REQ-012 ld:
- T3: Grb, BAout, Yin
- T4: Cout, ADD, Zin
- T5: Zlowout, MARin
- T6: Read, MDRin; hold in T6 until mem_ready=1
- T7: MDRout, Gra, Rin; then T0
REQ-013 st:
- T3–T5 as ld
- T6: Gra, Rout, MDRin, with Read=0
- T7: Write; hold in T7 until mem_ready=1, then T0
REQ-014 nop: T3 goes directly to T0 with all outputs 0.
REQ-015 halt: T3 goes to HALT. HALT: run=0, all strobes 0, held until reset.
REQ-016 Illegal opcode: T3 goes to HALT and sets illegal=1. illegal is cleared only by reset.
REQ-017 run=1 in every state except HALT.
REQ-018 mem_ready is ignored in every state except T1, T6 (ld) and T7 (st).
REQ-019 Cycle counts with mem_ready already high:
- ALU op / addi: 6 cycles
- ld, st: 8 cycles
- nop: 4 cycles

Reset
REQ-020 While reset=1, all control outputs are 0, run=0, illegal=0 and state=0. The first cycle after reset falls is T0 with run=1.
REQ-021 reset takes priority over every transition, including the T1/T6/T7 wait holds and HALT. An asserted reset abandons any in-flight instruction without issuing further strobes.
REQ-022 reset asserted in the same cycle as mem_ready=1 yields T0 after reset releases, not the waited state's successor.

Verification
REQ-023 Reset, then IRval=add (ra=1, rb=2, rc=3), mem_ready=1 -> states 0,1,2,3,4,5,0. T4 shows Grc, Rout, ADD, Zin. T5 shows Zlowout, Gra, Rin.
REQ-024 Fetch with mem_ready low for 3 cycles in T1 -> T1 held 4 cycles, Read=1 and MDRin=1 throughout, PCin=1 only in the first T1 cycle.
REQ-025 ld (ra=4, rb=0, C=0x55), mem_ready low 2 cycles in T6 -> T3 BAout, T4 Cout+ADD, T5 MARin, T6 held 3 cycles, T7 MDRout+Gra+Rin.
REQ-026 st, mem_ready low 1 cycle in T7 -> T6 Gra+Rout+MDRin, Write=1 for 2 cycles, then T0.
REQ-027 Opcode 11111 -> HALT, illegal=1, run=0, all strobes 0 for 10 further cycles. Reset then clears illegal and restarts at T0.
REQ-028 halt, then reset asserted in HALT -> state 0 and run=0 during reset, T0 with run=1 the cycle after release.
